i2c_target_ctrl: RTL and testbench

Byte-oriented I2C target (slave) controller. It sits directly downstream of `i2c_master` on the same two-wire bus. It decodes START/STOP conditions, matches a 7-bit address, ACKs and delivers written bytes to local logic, and serves read bytes from local logic. It is oversampled on the system clock (40 MHz nominal against 100 kHz SCL) and never drives SCL.

---
 rtl/i2c_target_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_target_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl
// Byte-oriented I2C target controller, oversampled on the system clock.
// Decodes START/STOP, matches a 7-bit address, ACKs and delivers written
// bytes, and serves read bytes fetched from local logic. Never drives SCL;
// only pulls SDA low or releases it.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   scl      bus clock from master (asynchronous to clk)
//   sda      bus data, open-drain (driven 0 or z)
//   tx_data  byte to return on a read, sampled while rd_req is high
//   rx_data  last byte written by the master
//   rx_valid one-cycle pulse, rx_data just updated
//   rd_req   one-cycle pulse, tx_data is being latched for the next read byte
//   busy     high from address match until STOP or a restarting START
//   done     one-cycle pulse at STOP ending an addressed transaction
module i2c_target_ctrl #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rd_req,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t     state;
  logic       drive_low;
  logic [2:0] bit_cnt;
  logic [6:0] shift_reg;
  logic [7:0] tx_shift;
  logic       rw;
  logic       byte_done;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  logic scl_rise, scl_fall, start_det, stop_det;

  assign sda = drive_low ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one extra stage for edge detection. They
  // reset to 1 (idle bus level) so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // START/STOP need SCL high on both sampled cycles so that an SDA change
  // coinciding with an SCL edge is not mistaken for a bus condition.
  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  // Main protocol FSM. START/STOP take priority over everything else.
  // byte_done marks "8th bit sampled, waiting for the SCL fall that opens
  // the ACK slot". tx_shift holds the not-yet-sent read bits MSB-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drive_low <= 1'b0;
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
      tx_shift  <= 8'd0;
      rw        <= 1'b0;
      byte_done <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rd_req    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rd_req   <= 1'b0;
      done     <= 1'b0;

      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
        byte_done <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        bit_cnt   <= 3'd0;
        drive_low <= 1'b0;
        busy      <= 1'b0;
        byte_done <= 1'b0;
        done      <= busy;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && !byte_done) begin
              shift_reg <= {shift_reg[5:0], sda_s2};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw <= sda_s2;
                if (shift_reg == TARGET_ADDR) begin
                  busy      <= 1'b1;
                  byte_done <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              drive_low <= 1'b1;
              state     <= ADDR_ACK;
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (rw) begin
                rd_req    <= 1'b1;
                tx_shift  <= {tx_data[6:0], 1'b0};
                drive_low <= ~tx_data[7];
                state     <= RD_DATA;
              end else begin
                drive_low <= 1'b0;
                state     <= WR_DATA;
              end
            end
          end

          WR_DATA: begin
            if (scl_rise && !byte_done) begin
              shift_reg <= {shift_reg[5:0], sda_s2};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= {shift_reg, sda_s2};
                rx_valid  <= 1'b1;
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              drive_low <= 1'b1;
              state     <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              drive_low <= 1'b0;
              state     <= WR_DATA;
            end
          end

          // bit_cnt counts bits already presented beyond bit 7; the fall
          // after bit 0 has been clocked out opens the master's ACK slot.
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                bit_cnt   <= 3'd0;
                drive_low <= 1'b0;
                state     <= RD_ACK;
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                drive_low <= ~tx_shift[7];
                tx_shift  <= {tx_shift[6:0], 1'b0};
              end
            end
          end

          RD_ACK: begin
            if (scl_rise && sda_s2) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              rd_req    <= 1'b1;
              tx_shift  <= {tx_data[6:0], 1'b0};
              drive_low <= ~tx_data[7];
              bit_cnt   <= 3'd0;
              state     <= RD_DATA;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// tb_i2c_target_ctrl
// Directed bench for i2c_target_ctrl. A bit-banged open-drain master runs
// the bus at 400 clk per bit; a monitor counts the one-cycle output pulses
// and logs every received byte.
module tb_i2c_target_ctrl;

  localparam int Q = 100;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       master_sda;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_req;
  logic       busy;
  logic       done;
  wire        sda_bus;

  int vectors     = 0;
  int miscompares = 0;

  int rx_cnt        = 0;
  int rd_cnt        = 0;
  int done_cnt      = 0;
  int slave_low_cnt = 0;
  logic [7:0] rx_log[$];

  pullup (sda_bus);
  assign sda_bus = master_sda ? 1'bz : 1'b0;

  i2c_target_ctrl #(.TARGET_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl_m),
    .sda      (sda_bus),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_req   (rd_req),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: a pulse lasting two cycles counts twice.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
    if (rd_req) rd_cnt++;
    if (done) done_cnt++;
    if (master_sda && sda_bus === 1'b0) slave_low_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full SCL clock: set data in the low phase, sample mid-high.
  task automatic applyStimulus(input logic send_bit, output logic sampled);
    wait_clks(Q);
    master_sda = send_bit;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    sampled = sda_bus;
    wait_clks(Q);
    scl_m = 1'b0;
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      master_sda = 1'b1;
      wait_clks(Q);
      scl_m = 1'b1;
      wait_clks(Q);
    end
    master_sda = 1'b0;
    wait_clks(Q);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    master_sda = 1'b0;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    master_sda = 1'b1;
    wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], dummy);
    applyStimulus(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b, output logic ack_slot);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, b[i]);
    applyStimulus(ack_bit, ack_slot);
  endtask

  initial begin
    logic       ack;
    logic       dummy;
    logic [7:0] rbyte;
    int rx0, rd0, done0, low0, log0;

    rst        = 1'b1;
    scl_m      = 1'b1;
    master_sda = 1'b1;
    tx_data    = 8'h00;
    wait_clks(5);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_rd_req", rd_req, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_sda", sda_bus, 1'b1);
    rst = 1'b0;
    wait_clks(10);

    // Single-byte write to our address
    $display("[TB] write 0x3C");
    rx0 = rx_cnt; done0 = done_cnt; log0 = rx_log.size();
    bus_start();
    write_byte(8'hA0, ack);
    checkOutput("wr_addr_ack", ack, 1'b0);
    checkOutput("wr_busy", busy, 1'b1);
    write_byte(8'h3C, ack);
    checkOutput("wr_data_ack", ack, 1'b0);
    bus_stop();
    checkOutput("wr_rx_count", rx_cnt - rx0, 1);
    checkOutput("wr_rx_byte", rx_log[log0], 8'h3C);
    checkOutput("wr_rx_data", rx_data, 8'h3C);
    checkOutput("wr_done_count", done_cnt - done0, 1);
    checkOutput("wr_busy_after", busy, 1'b0);

    // Single-byte read with master NACK
    $display("[TB] read 0xA5");
    tx_data = 8'hA5;
    rd0 = rd_cnt; done0 = done_cnt;
    bus_start();
    write_byte(8'hA1, ack);
    checkOutput("rd_addr_ack", ack, 1'b0);
    read_byte(1'b1, rbyte, ack);
    checkOutput("rd_byte", rbyte, 8'hA5);
    checkOutput("rd_ack_released", ack, 1'b1);
    checkOutput("rd_req_count", rd_cnt - rd0, 1);
    bus_stop();
    checkOutput("rd_done_count", done_cnt - done0, 1);
    checkOutput("rd_busy_after", busy, 1'b0);

    // Address mismatch
    $display("[TB] address mismatch");
    rx0 = rx_cnt; rd0 = rd_cnt; done0 = done_cnt; low0 = slave_low_cnt;
    bus_start();
    write_byte(8'h42, ack);
    checkOutput("mis_addr_nack", ack, 1'b1);
    checkOutput("mis_busy", busy, 1'b0);
    write_byte(8'hFF, ack);
    checkOutput("mis_data_nack", ack, 1'b1);
    bus_stop();
    checkOutput("mis_never_low", slave_low_cnt - low0, 0);
    checkOutput("mis_rx_count", rx_cnt - rx0, 0);
    checkOutput("mis_rd_count", rd_cnt - rd0, 0);
    checkOutput("mis_done_count", done_cnt - done0, 0);

    // Two-byte write, repeated START, two-byte read
    $display("[TB] multi-byte write + repeated start read");
    rx0 = rx_cnt; rd0 = rd_cnt; done0 = done_cnt; log0 = rx_log.size();
    bus_start();
    write_byte(8'hA0, ack);
    checkOutput("mb_addr_ack", ack, 1'b0);
    write_byte(8'h11, ack);
    checkOutput("mb_ack1", ack, 1'b0);
    write_byte(8'h22, ack);
    checkOutput("mb_ack2", ack, 1'b0);
    checkOutput("mb_rx_count", rx_cnt - rx0, 2);
    checkOutput("mb_rx_first", rx_log[log0], 8'h11);
    checkOutput("mb_rx_second", rx_log[log0 + 1], 8'h22);
    bus_start();
    checkOutput("mb_busy_restart", busy, 1'b0);
    tx_data = 8'h77;
    write_byte(8'hA1, ack);
    checkOutput("mb_rd_addr_ack", ack, 1'b0);
    checkOutput("mb_busy_rematch", busy, 1'b1);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b1, rbyte[i]);
    checkOutput("mb_rd_byte1", rbyte, 8'h77);
    tx_data = 8'h88;
    applyStimulus(1'b0, dummy);
    read_byte(1'b1, rbyte, ack);
    checkOutput("mb_rd_byte2", rbyte, 8'h88);
    checkOutput("mb_rd_ack_released", ack, 1'b1);
    checkOutput("mb_rd_req_count", rd_cnt - rd0, 2);
    bus_stop();
    checkOutput("mb_done_count", done_cnt - done0, 1);

    // Reset while the target holds the address ACK low
    $display("[TB] reset during address ACK");
    bus_start();
    for (int i = 7; i >= 0; i--) applyStimulus(rbyte[0] ^ rbyte[0] ^ ((8'hA0 >> i) & 1), dummy);
    wait_clks(Q);
    master_sda = 1'b1;
    wait_clks(Q);
    scl_m = 1'b1;
    wait_clks(Q);
    checkOutput("rst_ack_driven", sda_bus, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("rst_sda_released", sda_bus, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_rx_valid", rx_valid, 1'b0);
    checkOutput("rst_rd_req", rd_req, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    wait_clks(5);
    rst = 1'b0;
    wait_clks(Q);
    scl_m = 1'b0;
    done0 = done_cnt;
    bus_stop();
    checkOutput("rst_stop_no_done", done_cnt - done0, 0);
    rx0 = rx_cnt; done0 = done_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    checkOutput("post_rst_addr_ack", ack, 1'b0);
    write_byte(8'h5A, ack);
    checkOutput("post_rst_data_ack", ack, 1'b0);
    bus_stop();
    checkOutput("post_rst_rx_data", rx_data, 8'h5A);
    checkOutput("post_rst_rx_count", rx_cnt - rx0, 1);
    checkOutput("post_rst_done", done_cnt - done0, 1);

    // STOP after four data bits of a write
    $display("[TB] STOP mid data byte");
    rx0 = rx_cnt; done0 = done_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    checkOutput("part_addr_ack", ack, 1'b0);
    applyStimulus(1'b1, dummy);
    applyStimulus(1'b0, dummy);
    applyStimulus(1'b1, dummy);
    applyStimulus(1'b1, dummy);
    bus_stop();
    checkOutput("part_rx_count", rx_cnt - rx0, 0);
    checkOutput("part_done", done_cnt - done0, 1);
    checkOutput("part_busy", busy, 1'b0);
    checkOutput("part_rx_data_held", rx_data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
